imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, parametrised immediate generator for the RV32/RV64 datapath. It replaces the I-type-only combinational sign extender with full I/S/B/U/J plus shift-amount and CSR-immediate decoding. A valid/ready handshake and a two-entry skid buffer let it sit between the decode and execute stages, sustaining full throughput while propagating backpressure.

## Interface
- XLEN, 32: output width; legal values are 32 or 64.
- TAG_W, 5: width of the sideband tag (e.g. rd index) carried alongside each immediate.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept this cycle; driven directly from a register.
- in_raw  in  25  instruction bits [31:7]; in_raw[k] = instr[k+7].
- in_imm_src  in  3  format select, imm_src_t.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  out_imm, out_tag and out_illegal are valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  decoded immediate.
- out_tag  out  TAG_W  tag matching out_imm.
- out_illegal  out  1  in_imm_src was a reserved encoding.

## Operation
- **Decode:** combinational on the accepted input; all signed formats sign-extend from the top bit to XLEN.
  - 000 I: in_raw[24:13].
  - 001 S: {in_raw[24:18], in_raw[4:0]}.
  - 010 B: {in_raw[24], in_raw[0], in_raw[23:18], in_raw[4:1], 1'b0}.
  - 011 U: {in_raw[24:5], 12'b0}, sign-extended when XLEN=64.
  - 100 J: {in_raw[24], in_raw[12:5], in_raw[13], in_raw[23:14], 1'b0}.
  - 101 SHAMT: zero-extended. When XLEN=32 the source is in_raw[17:13]. When XLEN=64 it is in_raw[18:13].
  - 110 ZIMM: in_raw[12:8], zero-extended (CSR uimm).
  - 111 reserved: immediate is 0 and out_illegal=1.
- **Accept:** a transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- **Buffer:** consists of an output register (O) plus a skid register (S), each holding {imm, tag, illegal, valid}.
- **State** is the {O.valid, S.valid} pair, with three legal states:
  - EMPTY (0,0): accept loads O.
  - ONE (1,0):
    - accept with out_ready: O is reloaded from the input.
    - accept without out_ready: the input goes to S, and the state becomes FULL.
    - no accept with out_ready: go to EMPTY.
  - FULL (1,1): in_ready=0.
    - out_ready: O takes S, S clears, state becomes ONE.
    - otherwise: hold.
- **Other rules:**
  - State (0,1) is unreachable; an assertion checks it.
  - Decode happens before storage; S holds decoded values, so the output path has no combinational logic.
  - Ordering is strictly FIFO, with no drops and no duplicates.

## Timing
- **Reset:**
  - out_valid=0, out_imm=0, out_tag=0, out_illegal=0.
  - S cleared; in_ready=1 from the first cycle after reset deassertion.
- **Latency:** 1 cycle. An input accepted at edge N appears on the outputs after edge N, i.e. during cycle N+1.
- **Throughput:** 1 per cycle with out_ready held high.
- **in_ready** is registered: it equals !S.valid for the next cycle, so upstream sees no combinational dependency on out_ready.
- **Outputs** remain stable while out_valid && !out_ready.
- **Reset mid-operation:** asynchronous clear of both entries; any buffered immediates are discarded.
- **Simultaneous in/out transfer in ONE:** the state remains ONE with the new data in O.

## Structure
- **Package imm_pkg** contains:
  - imm_src_t enum: IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM, IMM_RSVD.
  - Entry struct typedef {imm, tag, illegal}.
- **Sub-module imm_decode** is the pure combinational format decoder, parametrised by XLEN. It is reused by the single-cycle core in place of the old extender.
- **The top level** holds the skid-buffer control and the registers.

## Test plan
- **Reset and I-type:**
  - Stimulus: reset, then I with instr 0xFFF00093 (in_raw=0x1FFE001), out_ready=1.
  - Required: out_imm=0xFFFFFFFF one cycle later; in_ready=1 throughout.
- **S/B/J sign handling:**
  - S, sw 0xFE20AE23 → 0xFFFFFFFC.
  - J, jal 0xFF9FF06F → 0xFFFFFFF8.
  - B, beq 0xFE000EE3 → 0xFFFFFFFC.
- **U, ZIMM and reserved:**
  - U, lui 0x123452B7 → 0x12345000.
  - XLEN=64, lui 0x800002B7 → 0xFFFFFFFF80000000.
  - ZIMM, raw bits [19:15]=0x1F → 0x1F.
  - src=111 → imm 0 with out_illegal=1.
- **Backpressure:**
  - Stimulus: stream of 4 tags (1,2,3,4) with out_ready=0 for 3 cycles.
  - Required: in_ready drops after 2 accepts, outputs stay frozen on tag 1, then tags emerge 1,2,3,4 in order with none lost.
- **Full throughput:**
  - Stimulus: 100 random back-to-back transfers with both valid and ready high.
  - Required: one output per cycle, matching the reference model.
- **Reset mid-FULL:**
  - Stimulus: assert rst_n low while in state FULL.
  - Required: out_valid=0 and in_ready=1 after release; stale tags never appear.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the immediate generator.
//   imm_src_t : 3-bit format select driven by the decoder control.
//   RAW_W     : width of the instruction slice handed to the generator (instr[31:7]).
package imm_pkg;

  localparam int RAW_W = 25;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_src_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode->execute immediate channel.
//   in_*  : upstream valid/ready with raw instruction bits, format and tag.
//   out_* : downstream valid/ready with decoded immediate, tag and illegal flag.
// master = the side driving instructions and consuming results; slave = imm_gen_pipe.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [RAW_W-1:0] in_raw;
  imm_src_t         in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_raw, in_imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_raw, in_imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_decode.sv
// Pure combinational RISC-V immediate decoder.
//   raw     : instr[31:7] (raw[k] = instr[k+7])
//   src     : format select
//   imm     : immediate, sign-extended (signed formats) or zero-extended to XLEN
//   illegal : src was the reserved encoding
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [RAW_W-1:0] raw,
  input  imm_src_t         src,
  output logic [XLEN-1:0]  imm,
  output logic             illegal
);
  // Every format fits in 32 bits; a signed 32-bit intermediate lets one
  // size cast handle the RV64 extension for all formats. Zero-extended
  // formats keep bit 31 clear so the cast leaves them unsigned.
  logic signed [31:0] v32;

  always_comb begin
    v32     = '0;
    illegal = 1'b0;
    case (src)
      IMM_I:     v32 = {{20{raw[24]}}, raw[24:13]};
      IMM_S:     v32 = {{20{raw[24]}}, raw[24:18], raw[4:0]};
      IMM_B:     v32 = {{19{raw[24]}}, raw[24], raw[0], raw[23:18], raw[4:1], 1'b0};
      IMM_U:     v32 = {raw[24:5], 12'b0};
      IMM_J:     v32 = {{11{raw[24]}}, raw[24], raw[12:5], raw[13], raw[23:14], 1'b0};
      // RV64 shifts use a 6-bit shamt; on RV32 bit 25 of the instruction is not part of it.
      IMM_SHAMT: v32 = {26'b0, (XLEN == 64) ? raw[18] : 1'b0, raw[17:13]};
      IMM_ZIMM:  v32 = {27'b0, raw[12:8]};
      default:   illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'(v32);
endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry skid buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imm_gen_pipe_if slave (in_* from decode, out_* to execute)
// Decode happens before storage, so out_* come straight from the O register.
// in_ready is registered as !S.valid so upstream never sees out_ready combinationally.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_gen_pipe_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  entry_t          dec_ent, o_ent, s_ent, o_nxt, s_nxt;
  logic            o_vld, s_vld, o_vld_nxt, s_vld_nxt;
  logic            in_rdy, accept;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .raw     (bus.in_raw),
    .src     (bus.in_imm_src),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign dec_ent = '{imm: dec_imm, tag: bus.in_tag, illegal: dec_ill};
  assign accept  = bus.in_valid && in_rdy;

  always_comb begin
    o_nxt     = o_ent;
    s_nxt     = s_ent;
    o_vld_nxt = o_vld;
    s_vld_nxt = s_vld;
    case ({o_vld, s_vld})
      2'b00: if (accept) begin
        o_nxt     = dec_ent;
        o_vld_nxt = 1'b1;
      end
      2'b10: begin
        if (accept && bus.out_ready) begin
          o_nxt = dec_ent;
        end else if (accept) begin
          s_nxt     = dec_ent;
          s_vld_nxt = 1'b1;
        end else if (bus.out_ready) begin
          o_vld_nxt = 1'b0;
        end
      end
      2'b11: if (bus.out_ready) begin
        o_nxt     = s_ent;
        s_vld_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ent  <= '0;
      s_ent  <= '0;
      o_vld  <= 1'b0;
      s_vld  <= 1'b0;
      in_rdy <= 1'b1;
    end else begin
      o_ent  <= o_nxt;
      s_ent  <= s_nxt;
      o_vld  <= o_vld_nxt;
      s_vld  <= s_vld_nxt;
      in_rdy <= !s_vld_nxt;
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = o_vld;
  assign bus.out_imm     = o_ent.imm;
  assign bus.out_tag     = o_ent.tag;
  assign bus.out_illegal = o_ent.illegal;

  // S only ever fills behind a valid O.
  a_no_skid_alone: assert property (@(posedge clk) disable iff (!rst_n) !(s_vld && !o_vld));
endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  import imm_pkg::*;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic clk, rst_n;
  int   checks = 0, failures = 0, outs = 0, cyc = 0;
  exp_t sb[$];
  exp_t got;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // Reference decoder written against standard instruction fields; returns {illegal, imm64}.
  function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] src, input bit x64);
    logic [63:0] v;
    logic        il;
    v  = '0;
    il = 1'b0;
    case (src)
      3'd0: v = {{52{ins[31]}}, ins[31:20]};
      3'd1: v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2: v = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: v = {{32{ins[31]}}, ins[31:12], 12'h000};
      3'd4: v = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd5: v = x64 ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
      3'd6: v = {59'b0, ins[19:15]};
      default: il = 1'b1;
    endcase
    return {il, v};
  endfunction

  // Called at posedge+1; leaves in_valid high and returns at posedge+1 after the accept edge.
  task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag,
                      input logic [31:0] e_imm, input logic e_ill);
    exp_t e;
    b32.in_valid   = 1'b1;
    b32.in_raw     = ins[31:7];
    b32.in_imm_src = imm_src_t'(src);
    b32.in_tag     = tag;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b32.in_ready) break;
    end
    if (b32.in_ready !== 1'b1) begin
      chk("in_ready_wait", {63'b0, b32.in_ready}, 64'd1);
      b32.in_valid = 1'b0;
      return;
    end
    e.imm = e_imm; e.tag = tag; e.ill = e_ill;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    b32.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic t64(input string nm, input logic [31:0] ins, input logic [2:0] src, input logic [63:0] e);
    b64.in_valid   = 1'b1;
    b64.in_raw     = ins[31:7];
    b64.in_imm_src = imm_src_t'(src);
    b64.in_tag     = 5'd3;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    chk({nm, "_valid"}, {63'b0, b64.out_valid}, 64'd1);
    chk(nm, b64.out_imm, e);
  endtask

  // Scoreboard monitor: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && b32.out_valid && b32.out_ready) begin
      outs++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_output observed_tag=%0d expected=none", b32.out_tag);
      end
      if (sb.size() != 0) begin
        got = sb.pop_front();
        chk("out_imm", {32'b0, b32.out_imm}, {32'b0, got.imm});
        chk("out_tag", {59'b0, b32.out_tag}, {59'b0, got.tag});
        chk("out_illegal", {63'b0, b32.out_illegal}, {63'b0, got.ill});
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [2:0]  src;
    logic [64:0] m;
    int          c0, n0;

    rst_n = 1'b0;
    b32.in_valid = 1'b0; b32.in_raw = '0; b32.in_imm_src = IMM_I; b32.in_tag = '0; b32.out_ready = 1'b0;
    b64.in_valid = 1'b0; b64.in_raw = '0; b64.in_imm_src = IMM_I; b64.in_tag = '0; b64.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", {63'b0, b32.out_valid}, 64'd0);
    chk("rst_out_imm", {32'b0, b32.out_imm}, 64'd0);
    chk("rst_out_tag", {59'b0, b32.out_tag}, 64'd0);
    chk("rst_out_illegal", {63'b0, b32.out_illegal}, 64'd0);
    chk("rst_in_ready", {63'b0, b32.in_ready}, 64'd1);
    @(posedge clk); #1;

    // I-type, one-cycle latency
    b32.out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 5'd1, 32'hFFFFFFFF, 1'b0);
    chk("lat_out_valid", {63'b0, b32.out_valid}, 64'd1);
    chk("lat_out_imm", {32'b0, b32.out_imm}, 64'hFFFFFFFF);
    chk("lat_in_ready", {63'b0, b32.in_ready}, 64'd1);

    // directed formats, back to back
    send(32'hFE20AE23, 3'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
    send(32'hFF9FF06F, 3'd4, 5'd3, 32'hFFFFFFF8, 1'b0);
    send(32'hFE000EE3, 3'd2, 5'd4, 32'hFFFFFFFC, 1'b0);
    send(32'h123452B7, 3'd3, 5'd5, 32'h12345000, 1'b0);
    send(32'h800002B7, 3'd3, 5'd6, 32'h80000000, 1'b0);
    send(32'h000F8000, 3'd6, 5'd7, 32'h0000001F, 1'b0);
    send(32'hFFFFFFFF, 3'd7, 5'd8, 32'h00000000, 1'b1);
    send(32'h02109093, 3'd5, 5'd9, 32'h00000001, 1'b0);
    idle(2);

    // RV64 instance
    t64("x64_lui", 32'h800002B7, 3'd3, 64'hFFFFFFFF80000000);
    t64("x64_addi", 32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF);
    t64("x64_shamt", 32'h02109093, 3'd5, 64'h21);

    // backpressure: O and S fill, in_ready drops, outputs freeze on tag 1
    b32.out_ready = 1'b0;
    send(32'h00500093, 3'd0, 5'd1, 32'h5, 1'b0);
    send(32'h00600093, 3'd0, 5'd2, 32'h6, 1'b0);
    b32.in_raw = 25'(32'h00700093 >> 7); b32.in_imm_src = IMM_I; b32.in_tag = 5'd3;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'b0, b32.in_ready}, 64'd0);
      chk("bp_out_tag", {59'b0, b32.out_tag}, 64'd1);
      chk("bp_out_imm", {32'b0, b32.out_imm}, 64'd5);
      @(posedge clk); #1;
    end
    b32.out_ready = 1'b1;
    send(32'h00700093, 3'd0, 5'd3, 32'h7, 1'b0);
    send(32'h00800093, 3'd0, 5'd4, 32'h8, 1'b0);
    idle(3);

    // full throughput with random formats
    c0 = cyc; n0 = outs;
    for (int i = 0; i < 100; i++) begin
      ins = $urandom;
      src = 3'($urandom_range(0, 7));
      m   = model(ins, src, 1'b0);
      send(ins, src, 5'(i), m[31:0], m[64]);
    end
    chk("tput_cycles", 64'(cyc - c0), 64'd100);
    idle(1);
    chk("tput_outputs", 64'(outs - n0), 64'd100);
    idle(2);

    // reset while FULL discards both entries
    b32.out_ready = 1'b0;
    send(32'h00A00093, 3'd0, 5'd17, 32'hA, 1'b0);
    send(32'h00B00093, 3'd0, 5'd18, 32'hB, 1'b0);
    chk("full_in_ready", {63'b0, b32.in_ready}, 64'd0);
    rst_n = 1'b0;
    b32.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", {63'b0, b32.out_valid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", {63'b0, b32.out_valid}, 64'd0);
    chk("post_rst_in_ready", {63'b0, b32.in_ready}, 64'd1);
    @(posedge clk); #1;
    b32.out_ready = 1'b1;
    idle(3);
    send(32'h00C00093, 3'd0, 5'd19, 32'hC, 1'b0);
    idle(3);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
